// File: rtl/lcd_ctrl_pkg.sv
// Shared types for the LCD image-buffer controller: command codes, FSM states
// and the row-major window address helper.
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE       = 4'd0,
    CMD_UP          = 4'd1,
    CMD_DOWN        = 4'd2,
    CMD_LEFT        = 4'd3,
    CMD_RIGHT       = 4'd4,
    CMD_MAX         = 4'd5,
    CMD_MIN         = 4'd6,
    CMD_AVG         = 4'd7,
    CMD_ROT_CCW     = 4'd8,
    CMD_ROT_CW      = 4'd9,
    CMD_MIRROR_X    = 4'd10,
    CMD_MIRROR_Y    = 4'd11,
    CMD_RECENTRE    = 4'd12,
    CMD_INVERT      = 4'd13,
    CMD_ILLEGAL_MIN = 4'd14
  } cmd_e;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_WAIT,
    ST_EXEC,
    ST_WRITE,
    ST_FINISH
  } state_e;

  function automatic int unsigned win_addr(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned img_w);
    return row * img_w + col;
  endfunction

endpackage

// File: rtl/lcd_ctrl_param_if.sv
// Host, image-ROM and image-RAM signals of the LCD controller. The slave
// modport is the controller side, the master modport is the host/memory side.
interface lcd_ctrl_param_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 6
);
  logic [3:0]        cmd;
  logic              cmd_valid;
  logic [PIX_W-1:0]  IROM_Q;
  logic              IROM_rd;
  logic [ADDR_W-1:0] IROM_A;
  logic              IRAM_valid;
  logic [PIX_W-1:0]  IRAM_D;
  logic [ADDR_W-1:0] IRAM_A;
  logic              busy;
  logic              done;
  logic              cmd_err;

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done, cmd_err
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done, cmd_err
  );
endinterface

// File: rtl/lcd_win_alu.sv
// Combinational arithmetic on the four pixels of the 2x2 edit window.
module lcd_win_alu #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] i_lu,
  input  logic [PIX_W-1:0] i_ru,
  input  logic [PIX_W-1:0] i_ld,
  input  logic [PIX_W-1:0] i_rd,
  output logic [PIX_W-1:0] o_max,
  output logic [PIX_W-1:0] o_min,
  output logic [PIX_W-1:0] o_avg,
  output logic [PIX_W-1:0] o_inv_lu,
  output logic [PIX_W-1:0] o_inv_ru,
  output logic [PIX_W-1:0] o_inv_ld,
  output logic [PIX_W-1:0] o_inv_rd
);
  logic [PIX_W-1:0] w_max_top, w_max_bot, w_min_top, w_min_bot;
  logic [PIX_W+1:0] w_sum;

  assign w_max_top = (i_lu > i_ru) ? i_lu : i_ru;
  assign w_max_bot = (i_ld > i_rd) ? i_ld : i_rd;
  assign w_min_top = (i_lu < i_ru) ? i_lu : i_ru;
  assign w_min_bot = (i_ld < i_rd) ? i_ld : i_rd;
  assign o_max     = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
  assign o_min     = (w_min_top < w_min_bot) ? w_min_top : w_min_bot;

  // Two guard bits hold the sum of four full-scale pixels without wrapping.
  assign w_sum = {2'b00, i_lu} + {2'b00, i_ru} + {2'b00, i_ld} + {2'b00, i_rd};
  assign o_avg = PIX_W'(w_sum >> 2);

  assign o_inv_lu = ~i_lu;
  assign o_inv_ru = ~i_ru;
  assign o_inv_ld = ~i_ld;
  assign o_inv_rd = ~i_rd;
endmodule

// File: rtl/lcd_ctrl_param.sv
// Image-buffer controller: loads a frame from ROM, edits a 2x2 window under
// host commands and streams the edited frame to RAM.
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input logic             clk,
  input logic             reset,
  lcd_ctrl_param_if.slave bus
);
  localparam int N   = IMG_W * IMG_H;
  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(IMG_W);
  localparam int AW1 = ADDR_W + 1;

  localparam logic [RW-1:0]     ROW_CTR   = RW'(IMG_H / 2);
  localparam logic [RW-1:0]     ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [RW-1:0]     ROW_ONE   = RW'(1);
  localparam logic [CW-1:0]     COL_CTR   = CW'(IMG_W / 2);
  localparam logic [CW-1:0]     COL_MAX   = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     COL_ONE   = CW'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = AW1'(1);
  localparam logic [ADDR_W:0]   CNT_TWO   = AW1'(2);
  localparam logic [ADDR_W:0]   CNT_N     = AW1'(N);
  localparam logic [ADDR_W:0]   CNT_END   = AW1'(N + 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);

  state_e            r_state;
  cmd_e              r_cmd;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [ADDR_W:0]   r_load_cnt;
  logic [PIX_W-1:0]  r_buf [N];

  logic              r_irom_rd, r_iram_valid, r_busy, r_done, r_cmd_err;
  logic [ADDR_W-1:0] r_irom_a, r_iram_a;
  logic [PIX_W-1:0]  r_iram_d;

  logic [ADDR_W-1:0] w_a_lu, w_a_ru, w_a_ld, w_a_rd, w_store_a;
  logic [PIX_W-1:0]  w_lu, w_ru, w_ld, w_rd;
  logic [PIX_W-1:0]  w_max, w_min, w_avg, w_inv_lu, w_inv_ru, w_inv_ld, w_inv_rd;

  // (r,c) is the lower-right corner of the window.
  assign w_a_lu = ADDR_W'(win_addr(32'(r_row) - 32'd1, 32'(r_col) - 32'd1, IMG_W));
  assign w_a_ru = ADDR_W'(win_addr(32'(r_row) - 32'd1, 32'(r_col), IMG_W));
  assign w_a_ld = ADDR_W'(win_addr(32'(r_row), 32'(r_col) - 32'd1, IMG_W));
  assign w_a_rd = ADDR_W'(win_addr(32'(r_row), 32'(r_col), IMG_W));
  assign w_store_a = ADDR_W'(r_load_cnt - CNT_TWO);

  assign w_lu = r_buf[w_a_lu];
  assign w_ru = r_buf[w_a_ru];
  assign w_ld = r_buf[w_a_ld];
  assign w_rd = r_buf[w_a_rd];

  lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
    .i_lu(w_lu), .i_ru(w_ru), .i_ld(w_ld), .i_rd(w_rd),
    .o_max(w_max), .o_min(w_min), .o_avg(w_avg),
    .o_inv_lu(w_inv_lu), .o_inv_ru(w_inv_ru),
    .o_inv_ld(w_inv_ld), .o_inv_rd(w_inv_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_LOAD;
      r_cmd        <= CMD_WRITE;
      r_row        <= ROW_CTR;
      r_col        <= COL_CTR;
      r_load_cnt   <= '0;
      r_irom_rd    <= 1'b0;
      r_irom_a     <= '0;
      r_iram_valid <= 1'b0;
      r_iram_d     <= '0;
      r_iram_a     <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          // ROM data trails its address by two edges; keep reading until stored.
          r_load_cnt <= r_load_cnt + CNT_ONE;
          if (r_load_cnt < CNT_N) begin
            r_irom_rd <= 1'b1;
            r_irom_a  <= ADDR_W'(r_load_cnt);
          end
          if (r_load_cnt >= CNT_TWO) r_buf[w_store_a] <= bus.IROM_Q;
          if (r_load_cnt == CNT_END) begin
            r_irom_rd  <= 1'b0;
            r_irom_a   <= '0;
            r_load_cnt <= '0;
            r_busy     <= 1'b0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.cmd_valid) begin
            r_cmd   <= cmd_e'(bus.cmd);
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_WAIT;
          r_busy  <= 1'b0;
          case (r_cmd)
            CMD_WRITE: begin
              r_state      <= ST_WRITE;
              r_busy       <= 1'b1;
              r_iram_valid <= 1'b1;
              r_iram_a     <= '0;
              r_iram_d     <= r_buf[0];
            end
            CMD_UP:    if (r_row > ROW_ONE) r_row <= r_row - ROW_ONE;
            CMD_DOWN:  if (r_row < ROW_MAX) r_row <= r_row + ROW_ONE;
            CMD_LEFT:  if (r_col > COL_ONE) r_col <= r_col - COL_ONE;
            CMD_RIGHT: if (r_col < COL_MAX) r_col <= r_col + COL_ONE;
            CMD_MAX: begin
              r_buf[w_a_lu] <= w_max; r_buf[w_a_ru] <= w_max;
              r_buf[w_a_ld] <= w_max; r_buf[w_a_rd] <= w_max;
            end
            CMD_MIN: begin
              r_buf[w_a_lu] <= w_min; r_buf[w_a_ru] <= w_min;
              r_buf[w_a_ld] <= w_min; r_buf[w_a_rd] <= w_min;
            end
            CMD_AVG: begin
              r_buf[w_a_lu] <= w_avg; r_buf[w_a_ru] <= w_avg;
              r_buf[w_a_ld] <= w_avg; r_buf[w_a_rd] <= w_avg;
            end
            CMD_ROT_CCW: begin
              r_buf[w_a_lu] <= w_ru; r_buf[w_a_ru] <= w_rd;
              r_buf[w_a_rd] <= w_ld; r_buf[w_a_ld] <= w_lu;
            end
            CMD_ROT_CW: begin
              r_buf[w_a_lu] <= w_ld; r_buf[w_a_ld] <= w_rd;
              r_buf[w_a_rd] <= w_ru; r_buf[w_a_ru] <= w_lu;
            end
            CMD_MIRROR_X: begin
              r_buf[w_a_lu] <= w_ld; r_buf[w_a_ld] <= w_lu;
              r_buf[w_a_ru] <= w_rd; r_buf[w_a_rd] <= w_ru;
            end
            CMD_MIRROR_Y: begin
              r_buf[w_a_lu] <= w_ru; r_buf[w_a_ru] <= w_lu;
              r_buf[w_a_ld] <= w_rd; r_buf[w_a_rd] <= w_ld;
            end
            CMD_RECENTRE: begin
              r_row <= ROW_CTR;
              r_col <= COL_CTR;
            end
            CMD_INVERT: begin
              r_buf[w_a_lu] <= w_inv_lu; r_buf[w_a_ru] <= w_inv_ru;
              r_buf[w_a_ld] <= w_inv_ld; r_buf[w_a_rd] <= w_inv_rd;
            end
            default: r_cmd_err <= 1'b1;
          endcase
        end
        ST_WRITE: begin
          if (r_iram_a == ADDR_LAST) begin
            r_iram_valid <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_FINISH;
          end else begin
            r_iram_a <= r_iram_a + ADDR_ONE;
            r_iram_d <= r_buf[r_iram_a + ADDR_ONE];
          end
        end
        ST_FINISH: begin
          r_state    <= ST_LOAD;
          r_load_cnt <= '0;
          r_irom_a   <= '0;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign bus.IROM_rd    = r_irom_rd;
  assign bus.IROM_A     = r_irom_a;
  assign bus.IRAM_valid = r_iram_valid;
  assign bus.IRAM_D     = r_iram_d;
  assign bus.IRAM_A     = r_iram_a;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.cmd_err    = r_cmd_err;
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench: 8x8x8 controller through five frames of edits, plus a
// 10-bit 16x4 instance for the wide-sum average.
module tb_lcd_ctrl_param;
  logic clk = 1'b0;
  logic reset1, reset2;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] rom1 [64];
  logic [9:0] rom2 [64];
  int         exp1 [64];
  int         exp2 [64];

  lcd_ctrl_param_if #(.PIX_W(8),  .ADDR_W(6)) if1 ();
  lcd_ctrl_param_if #(.PIX_W(10), .ADDR_W(6)) if2 ();

  lcd_ctrl_param #(.PIX_W(8), .IMG_W(8), .IMG_H(8)) dut (
    .clk(clk), .reset(reset1), .bus(if1)
  );
  lcd_ctrl_param #(.PIX_W(10), .IMG_W(16), .IMG_H(4)) dut2 (
    .clk(clk), .reset(reset2), .bus(if2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (if1.IROM_rd) if1.IROM_Q <= rom1[if1.IROM_A];
  always @(posedge clk) if (if2.IROM_rd) if2.IROM_Q <= rom2[if2.IROM_A];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic rom1_identity();
    for (int i = 0; i < 64; i++) rom1[i] = 8'(i);
  endtask

  task automatic exp1_identity();
    for (int i = 0; i < 64; i++) exp1[i] = i;
  endtask

  // Counts edges from the start of a load until busy drops; junk commands are
  // offered during the load and must be dropped silently.
  task automatic wait_load1(input string tag);
    int e = 0;
    int errs_seen = 0;
    if1.cmd = 4'd15;
    if1.cmd_valid = 1'b1;
    do begin
      tick();
      e++;
      if (e == 1) begin
        chk("load_first_rd", if1.IROM_rd, 1);
        chk("load_first_addr", if1.IROM_A, 0);
      end
      if (e == 2) chk("load_second_addr", if1.IROM_A, 1);
      if (e == 10) if1.cmd_valid = 1'b0;
      if (if1.cmd_err) errs_seen++;
    end while (if1.busy && e < 500);
    chk(tag, e, 66);
    chk("no_err_during_load", errs_seen, 0);
    tick();
    chk("idle_after_load", if1.busy, 0);
    $display("dut1 frame loaded after %0d cycles", e);
  endtask

  task automatic send1(input logic [3:0] c);
    chk("ready_before_cmd", if1.busy, 0);
    if1.cmd = c;
    if1.cmd_valid = 1'b1;
    tick();
    if1.cmd_valid = 1'b0;
    chk("busy_after_accept", if1.busy, 1);
    tick();
    $display("dut1 cmd %0d executed", c);
  endtask

  task automatic op1(input logic [3:0] c);
    send1(c);
    chk($sformatf("busy_after_cmd%0d", c), if1.busy, 0);
  endtask

  task automatic write1();
    send1(4'd0);
    for (int i = 0; i < 64; i++) begin
      chk("wr_valid", if1.IRAM_valid, 1);
      chk("wr_addr", if1.IRAM_A, i);
      chk($sformatf("wr_data_%0d", i), if1.IRAM_D, exp1[i]);
      tick();
    end
    chk("done_pulse", if1.done, 1);
    chk("valid_after_last", if1.IRAM_valid, 0);
    chk("busy_in_finish", if1.busy, 1);
    tick();
    chk("done_one_cycle", if1.done, 0);
    $display("dut1 frame written out (64 pixels)");
  endtask

  initial begin
    reset1 = 1'b0;
    reset2 = 1'b0;
    if1.cmd = 4'd0; if1.cmd_valid = 1'b0;
    if2.cmd = 4'd0; if2.cmd_valid = 1'b0;
    rom1_identity();
    for (int i = 0; i < 64; i++) rom2[i] = 10'(i);
    rom2[23] = 10'd1023; rom2[24] = 10'd1023;
    rom2[39] = 10'd1023; rom2[40] = 10'd1022;
    repeat (3) tick();

    chk("rst_irom_rd", if1.IROM_rd, 0);
    chk("rst_irom_a", if1.IROM_A, 0);
    chk("rst_iram_valid", if1.IRAM_valid, 0);
    chk("rst_iram_d", if1.IRAM_D, 0);
    chk("rst_iram_a", if1.IRAM_A, 0);
    chk("rst_busy", if1.busy, 1);
    chk("rst_done", if1.done, 0);
    chk("rst_cmd_err", if1.cmd_err, 0);
    chk("rst2_busy", if2.busy, 1);

    // Frame 1: plain ROM[a]=a straight out.
    reset1 = 1'b1;
    wait_load1("load_latency_reset");
    exp1_identity();
    write1();

    // Frame 2: up to the top edge, max, illegal command, recentre.
    wait_load1("load_latency_frame2");
    repeat (5) op1(4'd1);
    op1(4'd5);
    send1(4'd15);
    chk("cmd_err_pulse", if1.cmd_err, 1);
    chk("busy_after_illegal", if1.busy, 0);
    tick();
    chk("cmd_err_one_cycle", if1.cmd_err, 0);
    op1(4'd12);
    exp1_identity();
    exp1[3] = 12; exp1[4] = 12; exp1[11] = 12; exp1[12] = 12;
    rom1_identity();
    rom1[27] = 8'd10; rom1[28] = 8'd11; rom1[35] = 8'd12; rom1[36] = 8'd13;
    write1();

    // Frame 3: rotations and mirrors on {10,11,12,13} at (4,4).
    wait_load1("load_latency_frame3");
    op1(4'd8);
    op1(4'd9);
    op1(4'd8);
    op1(4'd10);
    op1(4'd11);
    exp1_identity();
    exp1[27] = 12; exp1[28] = 10; exp1[35] = 13; exp1[36] = 11;
    rom1[45] = 8'd0; rom1[46] = 8'd255; rom1[53] = 8'd1; rom1[54] = 8'd128;
    write1();

    // Frame 4: average, invert at (6,6), then bottom/right edges and min.
    wait_load1("load_latency_frame4");
    op1(4'd7);
    op1(4'd2); op1(4'd2); op1(4'd4); op1(4'd4);
    op1(4'd13);
    op1(4'd2); op1(4'd2); op1(4'd4); op1(4'd4);
    op1(4'd6);
    exp1_identity();
    exp1[27] = 11; exp1[28] = 11; exp1[35] = 11; exp1[36] = 11;
    exp1[45] = 255; exp1[46] = 0; exp1[53] = 254;
    exp1[54] = 55; exp1[55] = 55; exp1[62] = 55; exp1[63] = 55;
    rom1_identity();
    write1();

    // Frame 5: reset in the middle of write-out, then window back at centre.
    wait_load1("load_latency_frame5");
    send1(4'd0);
    repeat (20) tick();
    chk("wr_addr_before_reset", if1.IRAM_A, 20);
    reset1 = 1'b0;
    tick();
    chk("reset_mid_write_valid", if1.IRAM_valid, 0);
    chk("reset_mid_write_busy", if1.busy, 1);
    chk("reset_mid_write_addr", if1.IRAM_A, 0);
    tick();
    reset1 = 1'b1;
    wait_load1("load_latency_after_reset");
    op1(4'd5);
    exp1_identity();
    exp1[27] = 36; exp1[28] = 36; exp1[35] = 36; exp1[36] = 36;
    write1();

    // Wide-pixel instance: average of {1023,1023,1023,1022} at centre (2,8).
    reset2 = 1'b1;
    begin
      int e = 0;
      do begin tick(); e++; end while (if2.busy && e < 500);
      chk("load2_latency", e, 66);
    end
    if2.cmd = 4'd7;
    if2.cmd_valid = 1'b1;
    tick();
    if2.cmd_valid = 1'b0;
    tick();
    chk("dut2_busy_after_avg", if2.busy, 0);
    $display("dut2 cmd 7 executed");
    for (int i = 0; i < 64; i++) exp2[i] = i;
    exp2[23] = 1022; exp2[24] = 1022; exp2[39] = 1022; exp2[40] = 1022;
    if2.cmd = 4'd0;
    if2.cmd_valid = 1'b1;
    tick();
    if2.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) begin
      chk("wr2_valid", if2.IRAM_valid, 1);
      chk("wr2_addr", if2.IRAM_A, i);
      chk($sformatf("wr2_data_%0d", i), if2.IRAM_D, exp2[i]);
      tick();
    end
    chk("done2_pulse", if2.done, 1);
    $display("dut2 frame written out (64 pixels)");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
